// File: rtl/spi_resp_slave.sv
// SPI mode-0 responder: oversamples the SPI pins on clk, streams received bytes
// with their frame index, and returns response bytes from a local buffer.
//   state  | meaning
//   IDLE   | no frame; waiting for a qualified ss_n falling edge
//   ACTIVE | frame in progress; shifting bytes in on MOSI and out on MISO
module spi_resp_slave #(
  parameter int TX_DEPTH   = 256,
  parameter int TX_AW      = 8,
  parameter int RSP_OFFSET = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_ss_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             frame_start,
  output logic             frame_end,
  output logic [8:0]       frame_nbytes,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic [8:0]       rx_index,
  input  logic             tx_wr_en,
  input  logic [TX_AW-1:0] tx_wr_addr,
  input  logic [7:0]       tx_wr_data,
  output logic             busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state, state_nxt;
  logic [2:0] sclk_sync, ss_sync;
  logic [1:0] mosi_sync;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_q;
  logic [1:0] fill;
  logic       armed;
  logic       go_active, go_idle;
  logic [2:0] bit_cnt;
  logic [8:0] byte_cnt, byte_cnt_inc;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic       load_pend;
  logic [7:0] tx_buf [TX_DEPTH];
  logic [9:0] byte_ext, rsp_rel;
  logic       rsp_hit;
  logic [7:0] rsp_byte;

  // Edge pulses are registered so every pin event reaches the datapath 3 clk after the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 3'b000;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      mosi_q    <= 1'b0;
      fill      <= 2'd0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      ss_sync   <= {ss_sync[1:0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_rise <= sclk_sync[1] & ~sclk_sync[2];
      sclk_fall <= ~sclk_sync[1] & sclk_sync[2];
      ss_fall   <= ~ss_sync[1] & ss_sync[2];
      ss_rise   <= ss_sync[1] & ~ss_sync[2];
      mosi_q    <= mosi_sync[1];
      if (fill != 2'd3) fill <= fill + 2'd1;
      // Only arm once the synchronizer holds real pin samples showing ss_n high.
      if (fill == 2'd3 && ss_sync[2]) armed <= 1'b1;
    end
  end

  assign go_active = (state == IDLE) && ss_fall && armed;
  assign go_idle   = (state == ACTIVE) && ss_rise;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_active) state_nxt = ACTIVE;
      ACTIVE:  if (go_idle)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == ACTIVE);
    spi_miso_oe = (state == ACTIVE);
  end

  assign byte_cnt_inc = (byte_cnt == 9'd511) ? 9'd511 : byte_cnt + 9'd1;
  assign byte_ext     = {1'b0, byte_cnt};
  assign rsp_rel      = byte_ext - 10'(RSP_OFFSET);
  assign rsp_hit      = (byte_ext >= 10'(RSP_OFFSET)) && (rsp_rel < 10'(TX_DEPTH));
  assign rsp_byte     = rsp_hit ? tx_buf[rsp_rel[TX_AW-1:0]] : 8'h00;
  assign spi_miso     = tx_sr[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt      <= 3'd0;
      byte_cnt     <= 9'd0;
      rx_sr        <= 7'd0;
      tx_sr        <= 8'd0;
      load_pend    <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_nbytes <= 9'd0;
      rx_valid     <= 1'b0;
      rx_data      <= 8'd0;
      rx_index     <= 9'd0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      rx_valid    <= 1'b0;
      if (go_active) begin
        bit_cnt     <= 3'd0;
        byte_cnt    <= 9'd0;
        rx_sr       <= 7'd0;
        tx_sr       <= 8'd0;
        load_pend   <= 1'b0;
        frame_start <= 1'b1;
      end else if (go_idle) begin
        frame_end    <= 1'b1;
        frame_nbytes <= byte_cnt;
        bit_cnt      <= 3'd0;
        load_pend    <= 1'b0;
      end else if (state == ACTIVE) begin
        if (sclk_rise) begin
          rx_sr   <= {rx_sr[5:0], mosi_q};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_valid  <= 1'b1;
            rx_data   <= {rx_sr, mosi_q};
            rx_index  <= byte_cnt;
            byte_cnt  <= byte_cnt_inc;
            load_pend <= 1'b1;
          end
        end
        // byte_cnt already points at the next frame byte when the load happens.
        if (sclk_fall) begin
          if (load_pend) begin
            tx_sr     <= rsp_byte;
            load_pend <= 1'b0;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr_en) tx_buf[tx_wr_addr] <= tx_wr_data;
  end

endmodule

// File: tb/tb_spi_resp_slave.sv
// Bench for spi_resp_slave: a behavioural SPI master drives two responders
// (default parameters and a small offset-2 / depth-4 variant) and checks both.
module tb_spi_resp_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, frame_start, frame_end, rx_valid, busy;
  logic [8:0] frame_nbytes, rx_index;
  logic [7:0] rx_data;
  logic       tx_wr_en = 1'b0;
  logic [7:0] tx_wr_addr = 8'd0, tx_wr_data = 8'd0;

  logic       d2_miso, d2_oe, d2_fs, d2_fe, d2_rxv, d2_busy;
  logic [8:0] d2_nb, d2_rxi;
  logic [7:0] d2_rxd;
  logic       d2_wr_en = 1'b0;
  logic [1:0] d2_wr_addr = 2'd0;
  logic [7:0] d2_wr_data = 8'd0;

  spi_resp_slave dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .frame_start(frame_start), .frame_end(frame_end), .frame_nbytes(frame_nbytes),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_index(rx_index),
    .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr), .tx_wr_data(tx_wr_data),
    .busy(busy)
  );

  spi_resp_slave #(.TX_DEPTH(4), .TX_AW(2), .RSP_OFFSET(2)) dut2 (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(d2_miso), .spi_miso_oe(d2_oe),
    .frame_start(d2_fs), .frame_end(d2_fe), .frame_nbytes(d2_nb),
    .rx_valid(d2_rxv), .rx_data(d2_rxd), .rx_index(d2_rxi),
    .tx_wr_en(d2_wr_en), .tx_wr_addr(d2_wr_addr), .tx_wr_data(d2_wr_data),
    .busy(d2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbits;
    int          nb;
    logic [55:0] mo;
    logic [55:0] m1;
    logic [55:0] m2;
  } vec_t;

  vec_t        vecs[5];
  int          n_vec = 0, n_err = 0, n_fs = 0, n_fe = 0;
  logic [8:0]  nb_at_end = 9'd0;
  logic [16:0] exp_q[$];
  logic [7:0]  mo_bytes[$], got1[$], got2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: the master pushes {byte, index} on each 8th rising edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: got data %0h index %0d expected no rx_valid", rx_data, rx_index);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({rx_data, rx_index} !== e) begin
          n_err++;
          $display("FAIL rx_byte: got data %0h index %0d expected data %0h index %0d",
                   rx_data, rx_index, e[16:9], e[8:0]);
        end
      end
    end
    if (frame_start) n_fs++;
    if (frame_end) begin
      n_fe++;
      nb_at_end = frame_nbytes;
    end
  end

  task automatic wr1(input logic [7:0] a, input logic [7:0] d);
    tx_wr_en = 1'b1; tx_wr_addr = a; tx_wr_data = d;
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] a, input logic [7:0] d);
    d2_wr_en = 1'b1; d2_wr_addr = a; d2_wr_data = d;
    @(negedge clk);
    d2_wr_en = 1'b0;
  endtask

  task automatic spi_bits(input int nbits, input int half, input bit push);
    logic [7:0] b1, b2;
    b1 = 8'd0; b2 = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] cur;
      cur = mo_bytes[i / 8];
      spi_mosi = cur[7 - (i % 8)];
      repeat (half) @(negedge clk);
      b1 = {b1[6:0], spi_miso};
      b2 = {b2[6:0], d2_miso};
      spi_sclk = 1'b1;
      if (i % 8 == 7) begin
        got1.push_back(b1);
        got2.push_back(b2);
        if (push) exp_q.push_back({cur, (i / 8 > 511) ? 9'd511 : 9'(i / 8)});
      end
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int nbits, input int half);
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (half) @(negedge clk);
    if (half >= 4) check("busy_oe_in_frame", 32'({busy, spi_miso_oe}), 32'b11);
    spi_bits(nbits, half, 1'b1);
    repeat (half) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{nbits:24, nb:3, mo:56'hA53CFF00000000, m1:56'h00817E00000000, m2:56'h00000100000000};
    vecs[1] = '{nbits:12, nb:1, mo:56'h5AC30000000000, m1:56'h00000000000000, m2:56'h00000000000000};
    vecs[2] = '{nbits:16, nb:2, mo:56'h12340000000000, m1:56'h00810000000000, m2:56'h00000000000000};
    vecs[3] = '{nbits:56, nb:7, mo:56'h0123456789ABCD, m1:56'h00817E10203040, m2:56'h00000102030400};
    vecs[4] = '{nbits:8,  nb:1, mo:56'hC7000000000000, m1:56'h00000000000000, m2:56'h00000000000000};

    repeat (3) @(negedge clk);
    check("reset_outputs", {spi_miso, spi_miso_oe, busy, frame_start, frame_end, rx_valid,
                            rx_data, rx_index, frame_nbytes}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    wr1(8'd0, 8'h81); wr1(8'd1, 8'h7E); wr1(8'd2, 8'h10);
    wr1(8'd3, 8'h20); wr1(8'd4, 8'h30); wr1(8'd5, 8'h40);
    wr2(2'd0, 8'h01); wr2(2'd1, 8'h02); wr2(2'd2, 8'h03); wr2(2'd3, 8'h04);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      n_fs = 0; n_fe = 0;
      mo_bytes.delete(); got1.delete(); got2.delete();
      for (int k = 0; k < 7; k++) mo_bytes.push_back(vecs[i].mo[55 - 8 * k -: 8]);
      spi_xfer(vecs[i].nbits, 4);
      check($sformatf("v%0d_rx_drained", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_frame_start_cnt", i), 32'(n_fs), 32'd1);
      check($sformatf("v%0d_frame_end_cnt", i), 32'(n_fe), 32'd1);
      check($sformatf("v%0d_nbytes_at_end", i), 32'(nb_at_end), 32'(vecs[i].nb));
      check($sformatf("v%0d_nbytes_held", i), 32'(frame_nbytes), 32'(vecs[i].nb));
      check($sformatf("v%0d_idle_busy_oe", i), 32'({busy, spi_miso_oe}), 32'd0);
      for (int k = 0; k < vecs[i].nbits / 8; k++) begin
        check($sformatf("v%0d_miso1_b%0d", i, k), 32'(got1[k]), 32'(vecs[i].m1[55 - 8 * k -: 8]));
        check($sformatf("v%0d_miso2_b%0d", i, k), 32'(got2[k]), 32'(vecs[i].m2[55 - 8 * k -: 8]));
      end
    end

    // Buffer write during byte 0 must show up on byte 2 of the same frame.
    mo_bytes.delete(); got1.delete(); got2.delete();
    mo_bytes.push_back(8'h11); mo_bytes.push_back(8'h22); mo_bytes.push_back(8'h33);
    fork
      spi_xfer(24, 4);
      begin
        repeat (30) @(negedge clk);
        wr1(8'd1, 8'hC6);
      end
    join
    check("midwr_miso_b0", 32'(got1[0]), 32'h00);
    check("midwr_miso_b1", 32'(got1[1]), 32'h81);
    check("midwr_miso_b2", 32'(got1[2]), 32'hC6);

    // Reset mid-byte, released with ss_n still low.
    mo_bytes.delete(); got1.delete();
    mo_bytes.push_back(8'hF0); mo_bytes.push_back(8'h0F);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(5, 4, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_outputs", {spi_miso, spi_miso_oe, busy, frame_start, frame_end, rx_valid,
                               rx_data, rx_index, frame_nbytes}, 32'd0);
    reset = 1'b0;
    n_fs = 0; n_fe = 0;
    spi_bits(16, 4, 1'b0);
    check("postreset_ignored_fs", 32'(n_fs), 32'd0);
    check("postreset_ignored_busy", 32'(busy), 32'd0);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    mo_bytes.delete(); got1.delete();
    mo_bytes.push_back(8'h9C); mo_bytes.push_back(8'h63);
    spi_xfer(16, 4);
    check("postreset_frame_fs", 32'(n_fs), 32'd1);
    check("postreset_frame_fe", 32'(n_fe), 32'd1);
    check("postreset_nbytes", 32'(nb_at_end), 32'd2);
    check("postreset_miso_b1", 32'(got1[1]), 32'h81);

    // Byte counter saturation at 511 (sclk at clk/4).
    mo_bytes.delete(); got1.delete(); got2.delete();
    for (int k = 0; k < 513; k++) mo_bytes.push_back(8'(k * 7 + 3));
    spi_xfer(513 * 8, 2);
    check("sat_nbytes_at_end", 32'(nb_at_end), 32'd511);
    check("sat_nbytes_held", 32'(frame_nbytes), 32'd511);

    check("final_rx_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
